pixel_stream_tx: RTL and testbench
==================================

// Module: pixel_stream_tx
// PURPOSE
//  Frame-stream transmitter: reads a HEIGHT x WIDTH 8-bit image from a sync-read memory and emits the
//  Pixel/Frame/Line raster stream consumed by the Hough core and by the output capture handler.
//  Sending side of the same stream the capture handler decodes into (data, i, j, FrameOut).
//  Used as a synthesizable image source, replacing file-driven stimulus.
// PARAMETERS
//  WIDTH   64  pixels per line (2..256)
//  HEIGHT  64  lines per frame (2..256)
//  ADDR_W  12  memory address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT
// PORTS
//  Clk        in   1       system clock, all logic on rising edge
//  Reset      in   1       synchronous, active-high reset
//  Start      in   1       request one frame; sampled only in IDLE
//  Cont       in   1       1 = send frames back-to-back; sampled when last address of a frame is issued
//  RdEn       out  1       memory read enable
//  RdAddr     out  ADDR_W  memory read address, linear j*WIDTH+i
//  RdData     in   8       memory data, valid the cycle after RdEn/RdAddr
//  Pixel      out  8       pixel value
//  Frame      out  1       high with pixel (0,0) of each frame only
//  Line       out  1       high with pixel (0,j) of every line, including line 0
//  Busy       out  1       high from Start acceptance until the final pixel is output
//  FrameDone  out  1       one-cycle pulse coincident with the last pixel (WIDTH-1,HEIGHT-1)
//  TestPat    in   1       only present with STREAM_TX_TESTPAT_EN
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters i=j=0. Takes effect at the next edge, including mid-frame.
//    No FrameDone is issued for an aborted frame.
//  - States:
//    IDLE  -> FETCH  on Start.
//    FETCH -> FETCH  while addresses remain; at the last address, stays if Cont=1, else -> DRAIN.
//    DRAIN -> IDLE   after the final pixel is registered.
//  - FETCH: RdEn=1; RdAddr increments by 1 every cycle, 0..WIDTH*HEIGHT-1, then wraps to 0 when Cont=1.
//    i/j address counters: i wraps at WIDTH-1, then j increments; j wraps at HEIGHT-1.
//  - Output pipeline: two-stage coordinate shadow (matches 1-cycle memory latency plus output register).
//    Pixel/Frame/Line are registered. Pixel (0,0) is visible 2 cycles after the edge sampling Start.
//  - Pixels are contiguous: one per cycle, no blanking. Back-to-back frames have no gap.
//  - Inactive cycles: Pixel=0, Frame=0, Line=0.
//  - Busy rises the cycle after Start is accepted. It falls the cycle after the last pixel of the last frame.
//  - Start while Busy or DRAIN: ignored, not queued. Start held high in IDLE starts a new frame immediately.
//  - Cont drop mid-frame: the current frame completes, then stop. Cont is ignored in IDLE.
//  - Frame implies Line. FrameDone and Frame never coincide, since WIDTH*HEIGHT >= 4.
// CONFIGURATION
//  STREAM_TX_TESTPAT_EN defined:
//    TestPat input exists, sampled at Start.
//    TestPat=1: Pixel = (i+j) mod 256, RdEn held 0; timing, Frame/Line/Busy/FrameDone identical to memory mode.
//    TestPat=0: memory mode.
//  Not defined: no TestPat port; memory mode only.
// TESTING  (WIDTH=4, HEIGHT=3, mem[a]=a)
//  1. Reset held 3 cycles, then released -> Pixel/Frame/Line/RdEn/Busy/FrameDone all 0; RdAddr=0.
//  2. Start pulse, Cont=0:
//     -> Pixel 0..11 on 12 consecutive cycles from Start+2.
//     -> Frame only at Pixel=0; Line at Pixel=0,4,8; FrameDone at Pixel=11.
//     -> Busy low the next cycle; RdAddr sequence 0..11.
//  3. Cont=1, Start pulse:
//     -> Pixel 11 then 0 with Frame=1 on the next cycle; no gap.
//     -> Drop Cont during frame 2 -> stream ends after its Pixel=11; exactly 2 FrameDone pulses.
//  4. Start pulsed again at Pixel=6 -> ignored; 12 pixels only.
//     Start held high through end -> new frame Pixel=0 with Frame=1 at 2 cycles after IDLE re-entry.
//  5. Reset asserted at Pixel=5 -> next cycle all outputs 0, no FrameDone.
//     Subsequent Start -> restarts at RdAddr=0, Pixel=0 with Frame=1.
//  6. STREAM_TX_TESTPAT_EN, TestPat=1:
//     -> RdEn stays 0; Pixel at (i=3,j=2) = 5; Line at (0,1) with Pixel=1.

Source files
------------

// File: rtl/pixel_stream_tx.sv
// Frame-stream transmitter: walks a HEIGHT x WIDTH 8-bit image held in a sync-read memory and
// emits it as a contiguous Pixel/Frame/Line raster stream, one pixel per clock.
// Optional build macro STREAM_TX_TESTPAT_EN adds a TestPat input that replaces memory data with
// the (i+j) mod 256 diagonal ramp while keeping identical stream timing.
module pixel_stream_tx #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned HEIGHT = 64,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Cont,
`ifdef STREAM_TX_TESTPAT_EN
  input  logic              TestPat,
`endif
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [7:0]        RdData,
  output logic [7:0]        Pixel,
  output logic              Frame,
  output logic              Line,
  output logic              Busy,
  output logic              FrameDone
);

  localparam logic [7:0] ILast = 8'(WIDTH - 1);
  localparam logic [7:0] JLast = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain
  } state_e;

  state_e     state;

  // Coordinates of the address currently presented to the memory.
  logic [7:0] iCnt;
  logic [7:0] jCnt;

  // Stage-1 shadow: coordinates whose memory data appears on RdData this cycle.
  logic       s1Valid;
  logic [7:0] s1I;
  logic [7:0] s1J;

  // Test-pattern mode, latched when a frame request is accepted.
  logic       testPat;
  logic       testPatIn;
  logic       lastAddr;
  logic [7:0] patPixel;

`ifdef STREAM_TX_TESTPAT_EN
  assign testPatIn = TestPat;
`else
  assign testPatIn = 1'b0;
`endif

  assign lastAddr = (iCnt == ILast) && (jCnt == JLast);
  // 8-bit add wraps naturally, giving (i+j) mod 256.
  assign patPixel = s1I + s1J;

  // Control FSM: address generation, read strobe, busy flag and stage-1 coordinate shadow.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= StIdle;
      RdEn    <= 1'b0;
      RdAddr  <= '0;
      iCnt    <= '0;
      jCnt    <= '0;
      Busy    <= 1'b0;
      testPat <= 1'b0;
      s1Valid <= 1'b0;
      s1I     <= '0;
      s1J     <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          s1Valid <= 1'b0;
          RdAddr  <= '0;
          iCnt    <= '0;
          jCnt    <= '0;
          if (Start) begin
            state   <= StFetch;
            testPat <= testPatIn;
            RdEn    <= ~testPatIn;
            Busy    <= 1'b1;
          end else begin
            RdEn <= 1'b0;
            Busy <= 1'b0;
          end
        end

        StFetch: begin
          s1Valid <= 1'b1;
          s1I     <= iCnt;
          s1J     <= jCnt;
          if (lastAddr) begin
            // Cont is only looked at here, so dropping it mid-frame finishes that frame.
            RdAddr <= '0;
            iCnt   <= '0;
            jCnt   <= '0;
            if (!Cont) begin
              state <= StDrain;
              RdEn  <= 1'b0;
            end
          end else begin
            RdAddr <= RdAddr + 1'b1;
            if (iCnt == ILast) begin
              iCnt <= '0;
              jCnt <= jCnt + 1'b1;
            end else begin
              iCnt <= iCnt + 1'b1;
            end
          end
        end

        StDrain: begin
          // Final pixel is registered on this edge; Busy drops one cycle later in StIdle.
          s1Valid <= 1'b0;
          state   <= StIdle;
        end

        default: begin
          state   <= StIdle;
          RdEn    <= 1'b0;
          s1Valid <= 1'b0;
        end
      endcase
    end
  end

  // Output register stage: pixel value plus raster markers, all zero when no pixel is valid.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Pixel     <= '0;
      Frame     <= 1'b0;
      Line      <= 1'b0;
      FrameDone <= 1'b0;
    end else if (s1Valid) begin
      Pixel     <= testPat ? patPixel : RdData;
      Frame     <= (s1I == 8'd0) && (s1J == 8'd0);
      Line      <= (s1I == 8'd0);
      FrameDone <= (s1I == ILast) && (s1J == JLast);
    end else begin
      Pixel     <= '0;
      Frame     <= 1'b0;
      Line      <= 1'b0;
      FrameDone <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx at WIDTH=4, HEIGHT=3 with a memory holding mem[a]=a.
module tb_pixel_stream_tx;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 3;
  localparam int unsigned AW = 12;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Cont = 1'b0;
  logic          TestPat = 1'b0;
  logic          RdEn;
  logic [AW-1:0] RdAddr;
  logic [7:0]    RdData = 8'd0;
  logic [7:0]    Pixel;
  logic          Frame;
  logic          Line;
  logic          Busy;
  logic          FrameDone;

  int nChecks = 0;
  int nFail = 0;
  bit tpMode = 1'b0;
  int dones;

  pixel_stream_tx #(
    .WIDTH (W),
    .HEIGHT(H),
    .ADDR_W(AW)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Cont     (Cont),
`ifdef STREAM_TX_TESTPAT_EN
    .TestPat  (TestPat),
`endif
    .RdEn     (RdEn),
    .RdAddr   (RdAddr),
    .RdData   (RdData),
    .Pixel    (Pixel),
    .Frame    (Frame),
    .Line     (Line),
    .Busy     (Busy),
    .FrameDone(FrameDone)
  );

  always #5 Clk = ~Clk;

  // Sync-read memory with mem[a] = a.
  always @(posedge Clk) begin
    if (RdEn) RdData <= RdAddr[7:0];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Checks pixels first..first+count-1 of a stream (index k maps to k mod 12 within a frame).
  task automatic streamCheck(input int first, input int count, input int contDropAt,
                             input int startAt, output int nDone);
    int p;
    int pi;
    int pj;
    logic [7:0] expPix;
    nDone = 0;
    for (int k = first; k < first + count; k++) begin
      p  = k % 12;
      pi = p % 4;
      pj = p / 4;
      expPix = tpMode ? 8'(pi + pj) : 8'(p);
      tick(1);
      check("pixel", 32'(Pixel), 32'(expPix));
      check("frame", 32'(Frame), 32'(p == 0));
      check("line", 32'(Line), 32'(pi == 0));
      check("framedone", 32'(FrameDone), 32'(p == 11));
      check("busy", 32'(Busy), 32'd1);
      if (tpMode) check("rden_tp", 32'(RdEn), 32'd0);
      if (FrameDone) nDone++;
      if (k == contDropAt) Cont = 1'b0;
      if (k == startAt) Start = 1'b1;
      else if (startAt >= 0 && k == startAt + 1) Start = 1'b0;
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_pixel"}, 32'(Pixel), 32'd0);
    check({tag, "_frame"}, 32'(Frame), 32'd0);
    check({tag, "_line"}, 32'(Line), 32'd0);
    check({tag, "_rden"}, 32'(RdEn), 32'd0);
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    check({tag, "_framedone"}, 32'(FrameDone), 32'd0);
  endtask

  initial begin
    // 1. Reset
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(1);
    checkIdle("reset");
    check("reset_rdaddr", 32'(RdAddr), 32'd0);

    // 2. Single frame
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    check("f1_busy", 32'(Busy), 32'd1);
    check("f1_rden", 32'(RdEn), 32'd1);
    check("f1_rdaddr0", 32'(RdAddr), 32'd0);
    tick(1);
    check("f1_rdaddr1", 32'(RdAddr), 32'd1);
    check("f1_prepix_frame", 32'(Frame), 32'd0);
    streamCheck(0, 12, -1, -1, dones);
    check("f1_dones", 32'(dones), 32'd1);
    tick(1);
    checkIdle("f1_end");

    // 3. Back-to-back frames, Cont dropped during frame 2
    Cont = 1'b1;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(1);
    streamCheck(0, 24, 15, -1, dones);
    check("cont_dones", 32'(dones), 32'd2);
    tick(1);
    checkIdle("cont_end");

    // 4a. Start pulse mid-frame is ignored
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(1);
    streamCheck(0, 12, -1, 6, dones);
    check("ign_dones", 32'(dones), 32'd1);
    tick(1);
    checkIdle("ign_end");
    tick(1);
    checkIdle("ign_end2");

    // 4b. Start held high: new frame starts right after IDLE re-entry
    Start = 1'b1;
    tick(2);
    streamCheck(0, 12, -1, -1, dones);
    tick(1);
    check("held_gap1_pixel", 32'(Pixel), 32'd0);
    check("held_gap1_frame", 32'(Frame), 32'd0);
    check("held_gap1_busy", 32'(Busy), 32'd1);
    tick(1);
    check("held_gap2_frame", 32'(Frame), 32'd0);
    Start = 1'b0;
    streamCheck(0, 6, -1, -1, dones);

    // 5. Reset at Pixel=5 aborts the frame
    Reset = 1'b1;
    tick(1);
    checkIdle("abort");
    Reset = 1'b0;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    check("restart_rdaddr", 32'(RdAddr), 32'd0);
    check("restart_rden", 32'(RdEn), 32'd1);
    tick(1);
    streamCheck(0, 12, -1, -1, dones);
    check("restart_dones", 32'(dones), 32'd1);
    tick(1);
    checkIdle("restart_end");

`ifdef STREAM_TX_TESTPAT_EN
    // 6. Test pattern mode
    tpMode = 1'b1;
    TestPat = 1'b1;
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    TestPat = 1'b0;
    check("tp_rden", 32'(RdEn), 32'd0);
    check("tp_busy", 32'(Busy), 32'd1);
    tick(1);
    streamCheck(0, 12, -1, -1, dones);
    check("tp_dones", 32'(dones), 32'd1);
    tick(1);
    checkIdle("tp_end");
    tpMode = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
